// File: rtl/seq_pkg.sv
// Shared definitions for the "101" sequence-test path: FSM state encoding and default pattern.
// Used by the transmitter and by the detector on the far end of the link.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        FIN  = 2'b11
    } state_t;

    localparam int         DEF_PAT_LEN = 3;
    localparam logic [2:0] DEF_PATTERN = 3'b101;

endpackage

// File: rtl/seq_bit_shifter.sv
// Loadable MSB-first pattern shift register with bit index and last-bit flag; 1-cycle load/shift.
// No flow control: load has priority over shift, the owning FSM decides when either happens.
module seq_bit_shifter #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    output logic bit_out,
    output logic last
);

    localparam int IDX_W = $clog2(PAT_LEN);

    logic [PAT_LEN-1:0] sreg;
    logic [IDX_W-1:0]   idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= PATTERN;
            idx  <= IDX_W'(PAT_LEN - 1);
        end else if (shift) begin
            sreg <= {sreg[PAT_LEN-2:0], 1'b0};
            idx  <= idx - 1'b1;
        end
    end

    assign bit_out = sreg[PAT_LEN-1];
    assign last    = (idx == '0);

endmodule

// File: rtl/seq101_tx.sv
// Serial pattern transmitter: N repetitions of PATTERN with gap_len zeros between; first bit 2 edges after start.
// No backpressure: start is accepted only in IDLE, ignored (not queued) while busy or finishing.
module seq101_tx
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = 8,
    parameter int                 GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             y,
    output logic             y_valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_left;
    logic [GAP_W-1:0] gap_cfg;

    logic sh_load;
    logic sh_shift;
    logic sh_bit;
    logic sh_last;

    // Reload on the last bit so a back-to-back repetition starts without a bubble.
    assign sh_load  = ((state == IDLE) && start) || ((state == SEND) && sh_last);
    assign sh_shift = (state == SEND) && !sh_last;

    seq_bit_shifter #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .shift   (sh_shift),
        .bit_out (sh_bit),
        .last    (sh_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rep_left <= '0;
            gap_left <= '0;
            gap_cfg  <= '0;
            y        <= 1'b0;
            y_valid  <= 1'b0;
            frame    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            y       <= 1'b0;
            y_valid <= 1'b0;
            frame   <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rep_left <= repeat_cnt;
                        gap_cfg  <= gap_len;
                        busy     <= (repeat_cnt != '0);
                        state    <= (repeat_cnt == '0) ? FIN : SEND;
                    end
                end
                SEND: begin
                    y       <= sh_bit;
                    y_valid <= 1'b1;
                    frame   <= 1'b1;
                    if (sh_last) begin
                        rep_left <= rep_left - 1'b1;
                        if (rep_left == CNT_W'(1)) begin
                            state <= FIN;
                        end else if (gap_cfg != '0) begin
                            gap_left <= gap_cfg;
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    y_valid  <= 1'b1;
                    gap_left <= gap_left - 1'b1;
                    if (gap_left == GAP_W'(1)) begin
                        state <= SEND;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq101_tx.sv
// Bench for seq101_tx: per-cycle comparison against a queue-based model of the output stream,
// directed request scenarios with literal expectations, then randomized traffic.
module tb_seq101_tx;

    localparam int         PAT_LEN = 3;
    localparam logic [2:0] PAT     = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       y, y_valid, frame, busy, done;

    seq101_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .y          (y),
        .y_valid    (y_valid),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Model: on acceptance the whole future output stream {y,y_valid,frame,busy,done}
    // is laid out in a queue, one entry per cycle; an empty queue means idle.
    logic [4:0] q[$];
    logic [4:0] exp_out = '0;
    bit         cmp_en  = 1'b0;

    task automatic build(input int n, input int g);
        if (n == 0) begin
            q.push_back(5'b00000);
            q.push_back(5'b00001);
        end else begin
            q.push_back(5'b00010);
            for (int r = 0; r < n; r++) begin
                for (int b = PAT_LEN - 1; b >= 0; b--)
                    q.push_back({PAT[b], 4'b1110});
                if (r < n - 1)
                    for (int k = 0; k < g; k++) q.push_back(5'b01010);
            end
            q.push_back(5'b00001);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            exp_out = '0;
        end else if (q.size() == 0) begin
            if (start) build(int'(repeat_cnt), int'(gap_len));
            exp_out = (q.size() != 0) ? q.pop_front() : 5'b0;
        end else begin
            exp_out = q.pop_front();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) check("cycle_outputs", {59'b0, y, y_valid, frame, busy, done}, {59'b0, exp_out});
    end

    // One request from idle; index 0 is the cycle after the start edge.
    task automatic request(input int n, input int g, input int ncyc, input int pk, input int rst_at,
                           output logic [63:0] ybits, output logic [63:0] fbits, output int nvalid,
                           output int done_at, output int hits, output int busy_cnt);
        logic [2:0] h;
        h = '0; ybits = '0; fbits = '0; nvalid = 0; done_at = -1; hits = 0; busy_cnt = 0;
        start = 1'b1; repeat_cnt = 8'(n); gap_len = 4'(g);
        @(negedge clk);
        for (int i = 0; i < ncyc; i++) begin
            h = {h[1:0], y};
            if (h == 3'b101) hits++;
            if (y_valid) begin
                nvalid++;
                ybits = {ybits[62:0], y};
                fbits = {fbits[62:0], frame};
            end
            if (done && done_at < 0) done_at = i;
            if (busy) busy_cnt++;
            start      = (pk >= 0) && (i == 2 || i == 3 || i == pk);
            repeat_cnt = 8'd9;
            gap_len    = 4'($urandom_range(0, 15));
            rst        = !(i == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b1;
    endtask

    logic [63:0] yb, fb;
    int nv, da, hi, bc;

    initial begin
        rst = 1'b0; start = 1'b1; repeat_cnt = 8'd3; gap_len = 4'd1;
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_outputs_1", {59'b0, y, y_valid, frame, busy, done}, 64'd0);
        @(negedge clk);
        check("reset_outputs_2", {59'b0, y, y_valid, frame, busy, done}, 64'd0);
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {59'b0, y, y_valid, frame, busy, done}, 64'd0);

        request(1, 0, 6, -1, -1, yb, fb, nv, da, hi, bc);
        check("s2_y", yb[2:0], 3'b101);
        check("s2_frame", fb[2:0], 3'b111);
        check("s2_nvalid", nv, 3);
        check("s2_done_at", da, 4);
        check("s2_hits", hi, 1);
        check("s2_busy_cycles", bc, 4);

        request(2, 0, 9, -1, -1, yb, fb, nv, da, hi, bc);
        check("s3_y", yb[5:0], 6'b101101);
        check("s3_nvalid", nv, 6);
        check("s3_done_at", da, 7);
        check("s3_hits", hi, 2);

        request(3, 2, 17, -1, -1, yb, fb, nv, da, hi, bc);
        check("s4_y", yb[12:0], 13'b1010010100101);
        check("s4_frame", fb[12:0], 13'b1110011100111);
        check("s4_nvalid", nv, 13);
        check("s4_done_at", da, 14);
        check("s4_hits", hi, 3);

        request(0, 3, 4, -1, -1, yb, fb, nv, da, hi, bc);
        check("s5_zero_done_at", da, 1);
        check("s5_zero_busy", bc, 0);
        check("s5_zero_nvalid", nv, 0);

        // Starts during busy and during FIN must be ignored.
        request(2, 1, 12, 7, -1, yb, fb, nv, da, hi, bc);
        check("s5_poke_y", yb[6:0], 7'b1010101);
        check("s5_poke_nvalid", nv, 7);
        check("s5_poke_done_at", da, 8);
        check("s5_poke_busy", bc, 8);

        request(5, 1, 10, -1, 4, yb, fb, nv, da, hi, bc);
        check("s6_abort_nvalid", nv, 4);
        check("s6_abort_no_done", da, -1);
        request(1, 0, 6, -1, -1, yb, fb, nv, da, hi, bc);
        check("s6_fresh_y", yb[2:0], 3'b101);
        check("s6_fresh_done_at", da, 4);

        request(255, 15, 4600, -1, -1, yb, fb, nv, da, hi, bc);
        check("max_nvalid", nv, 4575);
        check("max_done_at", da, 4576);
        check("max_hits", hi, 255);

        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            repeat_cnt = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            gap_len    = 4'($urandom_range(0, 15));
            rst        = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b1;
        repeat (120) @(negedge clk);
        check("final_idle", {59'b0, y_valid, busy, done}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
